// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the ALU opcode set with iterative MULU/DIVU
package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_MULU = 4'hA,
        ALU_DIVU = 4'hB
    } aluop_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH);
    logic             busy, dmode;
    logic [WIDTH-1:0] m, acc, q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   madd, r2, dsub;
    // next iteration value; lo/hi hold the final product/quotient while done is high
    always_comb begin
        madd = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        r2   = {acc, q[WIDTH-1]};
        dsub = r2 - {1'b0, m};
        hi   = dmode ? (dsub[WIDTH] ? r2[WIDTH-1:0] : dsub[WIDTH-1:0]) : madd[WIDTH:1];
        lo   = dmode ? {q[WIDTH-2:0], ~dsub[WIDTH]} : {madd[0], q[WIDTH-1:1]};
        done = busy && cnt == CW'(WIDTH - 1);
    end
    // load operands on start, then iterate WIDTH times
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy  <= 1'b0;
            dmode <= 1'b0;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            dmode <= div;
            m     <= b;
            acc   <= '0;
            q     <= a;
            cnt   <= '0;
        end else if (busy) begin
            acc  <= hi;
            q    <= lo;
            cnt  <= cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: registered ALU with iterative unsigned multiply/divide and valid/ready handshake
module alu_iter
    import cpu_types_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MULDIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] porta,
    input  logic [WIDTH-1:0] portb,
    output logic             out_valid,
    output logic [WIDTH-1:0] portout,
    output logic [WIDTH-1:0] porthi,
    output logic             negative,
    output logic             overflow,
    output logic             zero
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t           state;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] add_r, sub_r, res, hi, md_lo, md_hi;
    logic             ovf, start, is_div, md_done;
    assign sh     = porta[SW-1:0];
    assign add_r  = porta + portb;
    assign sub_r  = porta - portb;
    assign is_div = aluop == ALU_DIVU;
    assign start  = in_valid && in_ready && MULDIV != 0
                    && (aluop == ALU_MULU || (is_div && portb != '0));
    // single-cycle result mux; divide-by-zero resolves here without iterating
    always_comb begin
        res = '0;
        hi  = '0;
        ovf = 1'b0;
        case (aluop)
            ALU_SLL:  res = portb << sh;
            ALU_SRL:  res = portb >> sh;
            ALU_ADD: begin
                res = add_r;
                ovf = porta[WIDTH-1] == portb[WIDTH-1] && add_r[WIDTH-1] != porta[WIDTH-1];
            end
            ALU_SUB: begin
                res = sub_r;
                ovf = porta[WIDTH-1] != portb[WIDTH-1] && sub_r[WIDTH-1] != porta[WIDTH-1];
            end
            ALU_AND:  res = porta & portb;
            ALU_OR:   res = porta | portb;
            ALU_XOR:  res = porta ^ portb;
            ALU_NOR:  res = ~(porta | portb);
            ALU_SLT:  res = WIDTH'($signed(porta) < $signed(portb));
            ALU_SLTU: res = WIDTH'(porta < portb);
            ALU_DIVU: if (MULDIV != 0 && portb == '0) begin
                res = '1;
                hi  = porta;
                ovf = 1'b1;
            end
            default: ;
        endcase
    end
    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .CLK  (CLK),
        .RST  (RST),
        .start(start),
        .div  (is_div),
        .a    (porta),
        .b    (portb),
        .done (md_done),
        .lo   (md_lo),
        .hi   (md_hi)
    );
    // control FSM with registered handshake and result outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            portout   <= '0;
            porthi    <= '0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state    <= is_div ? DIV : MUL;
                    in_ready <= 1'b0;
                end else if (in_valid) begin
                    out_valid <= 1'b1;
                    portout   <= res;
                    porthi    <= hi;
                    negative  <= res[WIDTH-1];
                    overflow  <= ovf;
                    zero      <= res == '0;
                end
            end else if (md_done) begin
                state     <= IDLE;
                in_ready  <= 1'b1;
                out_valid <= 1'b1;
                portout   <= md_lo;
                porthi    <= md_hi;
                negative  <= md_lo[WIDTH-1];
                overflow  <= state == MUL && md_hi != '0;
                zero      <= md_lo == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter at WIDTH=32
module tb_alu_iter;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  aluop = 4'h0;
    logic [31:0] porta = '0;
    logic [31:0] portb = '0;
    logic        out_valid;
    logic [31:0] portout;
    logic [31:0] porthi;
    logic        negative;
    logic        overflow;
    logic        zero;
    int          checks = 0;
    int          errors = 0;

    alu_iter #(.WIDTH(32), .MULDIV(1)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aluop    (aluop),
        .porta    (porta),
        .portb    (portb),
        .out_valid(out_valid),
        .portout  (portout),
        .porthi   (porthi),
        .negative (negative),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        aluop    = op;
        porta    = a;
        portb    = b;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic res(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                       input logic ov, input logic ng, input logic zr);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out"}, portout, lo);
        chk({tag, ".hi"}, porthi, hi);
        chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
        chk({tag, ".neg"}, 32'(negative), 32'(ng));
        chk({tag, ".zero"}, 32'(zero), 32'(zr));
    endtask

    initial begin
        #2 RST = 1'b1;
        #1;
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.out", portout, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        drive(1, 4'h2, 32'h7FFF_FFFF, 32'h1);
        tick();
        res("add_ovf", 32'h8000_0000, 32'h0, 1, 1, 0);
        drive(1, 4'h3, 32'd5, 32'd5);
        tick();
        res("sub_zero", 32'h0, 32'h0, 0, 0, 1);
        drive(0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("idle.valid", 32'(out_valid), 32'd0);
        chk("idle.hold", 32'(zero), 32'd1);
        drive(1, 4'hA, 32'hFFFF_FFFF, 32'h2);
        tick();
        drive(1, 4'h2, 32'h1, 32'h1);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("mul_busy%0d.ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("mul_busy%0d.valid", i), 32'(out_valid), 32'd0);
            if (i == 31) drive(0, 4'h0, 32'h0, 32'h0);
            tick();
        end
        res("mulu", 32'hFFFF_FFFE, 32'h1, 1, 1, 0);
        chk("mulu.ready", 32'(in_ready), 32'd1);
        tick();
        chk("mulu_after.valid", 32'(out_valid), 32'd0);
        chk("mulu_after.hold", portout, 32'hFFFF_FFFE);
        drive(1, 4'hB, 32'd100, 32'd7);
        tick();
        drive(0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("div_busy%0d.ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        res("divu", 32'd14, 32'd2, 0, 0, 0);
        drive(1, 4'hB, 32'd9, 32'd0);
        tick();
        drive(0, 4'h0, 32'h0, 32'h0);
        res("div0", 32'hFFFF_FFFF, 32'd9, 1, 1, 0);
        chk("div0.ready", 32'(in_ready), 32'd1);
        drive(1, 4'h0, 32'h24, 32'h1);
        tick();
        res("sll", 32'h10, 32'h0, 0, 0, 0);
        drive(1, 4'h8, 32'hFFFF_FFFF, 32'h1);
        tick();
        res("slt", 32'h1, 32'h0, 0, 0, 0);
        drive(1, 4'h9, 32'hFFFF_FFFF, 32'h1);
        tick();
        res("sltu", 32'h0, 32'h0, 0, 0, 1);
        drive(1, 4'h1, 32'hFF, 32'h8000_0000);
        tick();
        res("srl", 32'h1, 32'h0, 0, 0, 0);
        drive(1, 4'h7, 32'h0, 32'h0);
        tick();
        res("nor", 32'hFFFF_FFFF, 32'h0, 0, 1, 0);
        drive(1, 4'h3, 32'h8000_0000, 32'h1);
        tick();
        res("sub_ovf", 32'h7FFF_FFFF, 32'h0, 1, 0, 0);
        drive(1, 4'hF, 32'h1234, 32'h5678);
        tick();
        res("undef", 32'h0, 32'h0, 0, 0, 1);
        drive(1, 4'hA, 32'd3, 32'd3);
        tick();
        drive(0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) tick();
        chk("mul_abort.busy", 32'(in_ready), 32'd0);
        #2 RST = 1'b1;
        #1;
        chk("mul_abort.ready", 32'(in_ready), 32'd1);
        chk("mul_abort.valid", 32'(out_valid), 32'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("abort%0d.valid", i), 32'(out_valid), 32'd0);
            tick();
        end
        drive(1, 4'h2, 32'd2, 32'd3);
        tick();
        drive(0, 4'h0, 32'h0, 32'h0);
        res("add_after_abort", 32'd5, 32'h0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
